dispatch_unit: RTL and testbench

In-order dispatch stage that feeds the per-FU schedulers: accepts renamed instructions through a 2-entry skid buffer, routes each to its target FU scheduler, and builds the scheduler's `dependency_mask` from a preg→producer table. The table is updated on every dispatch and cleared by `global_ready_mask` wakeups. It is the initiator side of the dispatch→scheduler handshake (`disp_valid`, `disp_pkt`, `dependency_mask`, `rs_full`, `rs_entry_idx`).

---
 rtl/dispatch_unit.sv | 106 ++++++++++
 tb/tb_dispatch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dispatch_unit.sv
// dispatch_unit: in-order dispatch through a 2-entry skid buffer to per-FU schedulers,
// building each head's dependency_mask from a preg-to-producer table.
package dispatch_pkg;
  typedef struct packed {
    logic       instr_valid;
    logic [7:0] op;
    logic [5:0] dst;
    logic [5:0] src1;
    logic [5:0] src2;
  } disp_packet_t;
endpackage

module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int RS_ENTRIES = 8,
  parameter int NUM_FUS    = 2,
  parameter int NUM_PREGS  = 64,
  localparam int NB = RS_ENTRIES * NUM_FUS,
  localparam int FW = NUM_FUS > 1 ? $clog2(NUM_FUS) : 1,
  localparam int EW = RS_ENTRIES > 1 ? $clog2(RS_ENTRIES) : 1,
  localparam int PW = NB > 1 ? $clog2(NB) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ren_valid,
  output logic                  ren_ready,
  input  disp_packet_t          ren_pkt,
  input  logic [FW-1:0]         ren_fu,
  output logic [NUM_FUS-1:0]    disp_valid,
  output disp_packet_t          disp_pkt,
  output logic [NB-1:0]         dependency_mask,
  input  logic [NUM_FUS-1:0]    rs_full,
  input  logic [NUM_FUS*EW-1:0] rs_entry_idx,
  input  logic [NB-1:0]         global_ready_mask,
  output logic [31:0]           stall_count
);
  disp_packet_t         pkt_q [2];
  logic [FW-1:0]        fu_q [2];
  logic [1:0]           cnt, cnt_n;
  logic [NUM_PREGS-1:0] pending;
  logic [PW-1:0]        prod [NUM_PREGS];
  logic [NB-1:0]        dep;
  logic [PW-1:0]        b;
  logic                 head_valid, fire, enq, slot;
  assign head_valid = cnt != 2'd0;
  assign fire       = head_valid && !rs_full[fu_q[0]] && !flush;
  assign enq        = ren_valid && ren_ready && !flush;
  assign slot       = cnt == 2'd1 && !fire;
  assign cnt_n      = cnt + {1'b0, enq} - {1'b0, fire};
  assign disp_pkt   = head_valid ? pkt_q[0] : '0;
  assign b = PW'(int'(fu_q[0]) * RS_ENTRIES + int'(rs_entry_idx[int'(fu_q[0]) * EW +: EW]));
  always_comb begin
    dep = '0;
    if (disp_pkt.src1 != 6'd0 && pending[disp_pkt.src1]) dep[prod[disp_pkt.src1]] = 1'b1;
    if (disp_pkt.src2 != 6'd0 && pending[disp_pkt.src2]) dep[prod[disp_pkt.src2]] = 1'b1;
    dependency_mask = disp_pkt.instr_valid ? dep & ~global_ready_mask : '0;
  end
  always_comb begin
    disp_valid = '0;
    for (int f = 0; f < NUM_FUS; f++) disp_valid[f] = fire && fu_q[0] == FW'(f);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 2'd0;
      ren_ready   <= 1'b1;
      pkt_q       <= '{default: '0};
      fu_q        <= '{default: '0};
      stall_count <= 32'd0;
    end else begin
      if (head_valid && rs_full[fu_q[0]] && stall_count != '1) stall_count <= stall_count + 32'd1;
      if (flush) begin
        cnt       <= 2'd0;
        ren_ready <= 1'b1;
      end else begin
        cnt       <= cnt_n;
        ren_ready <= cnt_n < 2'd2;
        if (fire) begin
          pkt_q[0] <= pkt_q[1];
          fu_q[0]  <= fu_q[1];
        end
        if (enq) begin
          pkt_q[slot] <= ren_pkt;
          fu_q[slot]  <= ren_fu;
        end
      end
    end
  end
  // A new producer for a preg outranks a same-cycle wakeup of its old producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      prod    <= '{default: '0};
    end else begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        if (flush) pending[p] <= 1'b0;
        else if (fire && disp_pkt.dst != 6'd0 && int'(disp_pkt.dst) == p) begin
          pending[p] <= 1'b1;
          prod[p]    <= b;
        end else if (pending[p] && (global_ready_mask[prod[p]] || (fire && prod[p] == b)))
          pending[p] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: directed dispatch scenarios with a queue-based scoreboard and
// a negedge monitor that checks every dispatch strobe against the queue.
module tb_dispatch_unit;
  import dispatch_pkg::*;
  typedef struct packed {
    logic [1:0]   dv;
    disp_packet_t pkt;
    logic [15:0]  mask;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst, flush, ren_valid, ren_ready;
  disp_packet_t ren_pkt, disp_pkt;
  logic [0:0]   ren_fu;
  logic [1:0]   disp_valid, rs_full;
  logic [15:0]  dependency_mask, grm;
  logic [5:0]   rs_entry_idx;
  logic [31:0]  stall_count;
  exp_t         q[$];
  exp_t         e;
  int           passed = 0, total = 0;
  dispatch_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .ren_valid(ren_valid), .ren_ready(ren_ready),
    .ren_pkt(ren_pkt), .ren_fu(ren_fu), .disp_valid(disp_valid), .disp_pkt(disp_pkt),
    .dependency_mask(dependency_mask), .rs_full(rs_full), .rs_entry_idx(rs_entry_idx),
    .global_ready_mask(grm), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) $display("FAIL %s: got %0h expected %0h", n, a, x);
    else passed++;
  endtask
  function automatic disp_packet_t mk(input logic [7:0] op, input logic [5:0] d, s1, s2);
    mk = '{instr_valid: 1'b1, op: op, dst: d, src1: s1, src2: s2};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_disp(input disp_packet_t p, input logic [0:0] fu, input logic [15:0] m);
    q.push_back('{dv: fu ? 2'b10 : 2'b01, pkt: p, mask: m});
  endtask
  task automatic send(input disp_packet_t p, input logic [0:0] fu, input logic [15:0] m);
    int i;
    expect_disp(p, fu, m);
    ren_valid = 1'b1;
    ren_pkt   = p;
    ren_fu    = fu;
    for (i = 0; i < 20 && !ren_ready; i++) step();
    if (i == 20) check("accept_timeout", 0, 1);
    step();
    ren_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && disp_valid != 2'b00) begin
      if (q.size() == 0) check("unexpected_dispatch", {62'd0, disp_valid}, 0);
      else begin
        e = q.pop_front();
        check($sformatf("disp_valid op%0d", e.pkt.op), {62'd0, disp_valid}, {62'd0, e.dv});
        check($sformatf("disp_pkt op%0d", e.pkt.op), {37'd0, disp_pkt}, {37'd0, e.pkt});
        check($sformatf("dep_mask op%0d", e.pkt.op), {48'd0, dependency_mask}, {48'd0, e.mask});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; flush = 1'b0; ren_valid = 1'b0; ren_pkt = '0; ren_fu = 1'b0;
    rs_full = 2'b00; rs_entry_idx = 6'd0; grm = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ren_ready", ren_ready, 1);
    check("reset_disp_valid", disp_valid, 0);
    check("reset_mask", dependency_mask, 0);
    check("reset_disp_pkt", disp_pkt, 0);
    check("reset_stall", stall_count, 0);
    // producer chain, wakeups and same-cycle wakeup masking
    rs_entry_idx = {3'd0, 3'd0};
    send(mk(1, 10, 20, 30), 0, 16'h0000); step();
    rs_entry_idx = {3'd3, 3'd0};
    send(mk(2, 15, 10, 0), 1, 16'h0001); step();
    grm = 16'h0001; step(); grm = 16'h0;
    send(mk(3, 0, 10, 0), 0, 16'h0000); step();
    send(mk(4, 0, 15, 0), 0, 16'h0000); grm = 16'h0800; step(); grm = 16'h0;
    // src == dst, dst 0, stale slot reuse
    rs_entry_idx = {3'd3, 3'd4};
    send(mk(5, 7, 1, 0), 0, 16'h0000); step();
    rs_entry_idx = {3'd3, 3'd5};
    send(mk(6, 7, 7, 0), 0, 16'h0010); step();
    send(mk(7, 0, 7, 0), 1, 16'h0020); step();
    send(mk(8, 0, 0, 0), 1, 16'h0000); step();
    send(mk(9, 9, 0, 0), 0, 16'h0000); step();
    send(mk(10, 0, 7, 0), 1, 16'h0000); step();
    // full scheduler stall, then release with back-to-back dispatch
    rs_entry_idx = {3'd3, 3'd1};
    rs_full = 2'b01;
    expect_disp(mk(11, 11, 9, 0), 0, 16'h0020);
    expect_disp(mk(12, 12, 11, 0), 0, 16'h0002);
    expect_disp(mk(13, 0, 12, 11), 0, 16'h0002);
    ren_valid = 1'b1; ren_fu = 1'b0; ren_pkt = mk(11, 11, 9, 0); step();
    check("stall_no_disp", disp_valid, 0);
    ren_pkt = mk(12, 12, 11, 0); step();
    ren_pkt = mk(13, 0, 12, 11);
    check("ren_ready_full", ren_ready, 0);
    repeat (4) step();
    check("stall_count_5", stall_count, 5);
    rs_full = 2'b00;
    @(negedge clk) check("release_c1", disp_valid, 2'b01);
    @(posedge clk) #1;
    check("ren_ready_reopen", ren_ready, 1);
    @(negedge clk) check("release_c2", disp_valid, 2'b01);
    @(posedge clk) #1 ren_valid = 1'b0;
    @(negedge clk) check("release_c3", disp_valid, 2'b01);
    step();
    check("stall_count_hold", stall_count, 5);
    // flush with two buffered instructions and three pending pregs
    rs_entry_idx = {3'd6, 3'd1};
    send(mk(14, 14, 0, 0), 1, 16'h0000); step();
    rs_full = 2'b11;
    ren_valid = 1'b1; ren_fu = 1'b0; ren_pkt = mk(15, 0, 9, 12); step();
    ren_pkt = mk(16, 0, 0, 0); step();
    flush = 1'b1; rs_full = 2'b00; ren_valid = 1'b0;
    @(negedge clk) check("flush_no_disp", disp_valid, 0);
    @(posedge clk) #1 flush = 1'b0;
    check("flush_ren_ready", ren_ready, 1);
    check("flush_disp_valid", disp_valid, 0);
    check("flush_mask", dependency_mask, 0);
    check("flush_stall_kept", stall_count, 6);
    send(mk(17, 0, 9, 12), 0, 16'h0000); step();
    send(mk(18, 0, 14, 0), 1, 16'h0000); step();
    // asynchronous reset while stalled with a full buffer
    rs_full = 2'b01;
    ren_valid = 1'b1; ren_fu = 1'b0; ren_pkt = mk(19, 5, 9, 0); step();
    ren_pkt = mk(20, 6, 5, 0); step();
    ren_valid = 1'b0; step();
    check("pre_reset_ren_ready", ren_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("async_ren_ready", ren_ready, 1);
    check("async_disp_valid", disp_valid, 0);
    check("async_mask", dependency_mask, 0);
    check("async_disp_pkt", disp_pkt, 0);
    check("async_stall", stall_count, 0);
    @(posedge clk) #1;
    rs_full = 2'b00; rst = 1'b0;
    repeat (3) step();
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
